// File: rtl/pid_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// pid_channel_scheduler_if
//
// Purpose: bundles the start/done handshake and data buses between the
// channel scheduler and the single shared PID compute engine.
//
// Signals:
//   eng_start         scheduler -> engine  one-cycle start pulse
//   eng_ch            scheduler -> engine  channel being served
//   eng_setpoint      scheduler -> engine  setpoint snapshot of that channel
//   eng_feedback      scheduler -> engine  feedback snapshot of that channel
//   eng_prev_error    scheduler -> engine  stored previous error
//   eng_integral      scheduler -> engine  stored integral accumulator
//   eng_done          engine -> scheduler  single-cycle result valid pulse
//   eng_control       engine -> scheduler  control result
//   eng_error         engine -> scheduler  error for this sample
//   eng_integral_nxt  engine -> scheduler  updated integral
//
// Modports: master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface pid_channel_scheduler_if #(
  parameter int NCH = 4
);
  localparam int CH_W = $clog2(NCH);

  logic            eng_start;
  logic [CH_W-1:0] eng_ch;
  logic [7:0]      eng_setpoint;
  logic [7:0]      eng_feedback;
  logic [15:0]     eng_prev_error;
  logic [15:0]     eng_integral;
  logic            eng_done;
  logic [7:0]      eng_control;
  logic [15:0]     eng_error;
  logic [15:0]     eng_integral_nxt;

  modport master (
    output eng_start,
    output eng_ch,
    output eng_setpoint,
    output eng_feedback,
    output eng_prev_error,
    output eng_integral,
    input  eng_done,
    input  eng_control,
    input  eng_error,
    input  eng_integral_nxt
  );

  modport slave (
    input  eng_start,
    input  eng_ch,
    input  eng_setpoint,
    input  eng_feedback,
    input  eng_prev_error,
    input  eng_integral,
    output eng_done,
    output eng_control,
    output eng_error,
    output eng_integral_nxt
  );
endinterface

// File: rtl/pid_channel_scheduler.sv
// ---------------------------------------------------------------------------
// pid_channel_scheduler
//
// Purpose: time-shares one PID compute engine among NCH control loops.
// Sample requests are latched per channel, granted round-robin and issued
// to the engine over a start/done handshake. The per-channel loop state
// (previous error, integral) and the registered control outputs live here;
// the 16-bit state is stored and handed back untouched.
//
// Ports:
//   clk          clock, everything on the rising edge
//   rst_n        synchronous active-low reset
//   req          per-channel sample request (each high cycle = one request)
//   setpoint     per-channel setpoints, channel i at [8i+7:8i]
//   feedback     per-channel measured values, same packing
//   clr_err      clears the overrun and timeout sticky flags
//   eng          engine handshake/bus (master side)
//   control_out  registered per-channel control values
//   ch_valid     one-cycle pulse when control_out[i] updates
//   busy         high whenever the FSM is not in IDLE
//   overrun      sticky: request arrived while channel already pending
//   timeout_err  sticky: engine did not answer within TIMEOUT cycles
// ---------------------------------------------------------------------------
module pid_channel_scheduler #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req,
  input  logic [8*NCH-1:0]       setpoint,
  input  logic [8*NCH-1:0]       feedback,
  input  logic                   clr_err,
  pid_channel_scheduler_if.master eng,
  output logic [8*NCH-1:0]       control_out,
  output logic [NCH-1:0]         ch_valid,
  output logic                   busy,
  output logic [NCH-1:0]         overrun,
  output logic                   timeout_err
);

  localparam int CH_W  = $clog2(NCH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [NCH-1:0]  pending;
  logic [CH_W-1:0] last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic [15:0]     prev_error [NCH];
  logic [15:0]     integral   [NCH];

  logic [7:0]      cap_control;
  logic [15:0]     cap_error;
  logic [15:0]     cap_integral;

  logic            grant_any;
  logic [CH_W-1:0] grant_ch;
  logic [NCH-1:0]  grant_clear;

  logic            do_grant;
  logic            do_capture;
  logic            do_timeout;
  logic            do_wb;

  // Round-robin search: channels above last_grant are preferred in
  // ascending order; if none is pending, wrap and take the lowest channel
  // at or below last_grant. Split into two scans so every index is a
  // constant after unrolling.
  always_comb begin : grant_search
    logic            hi_found;
    logic            lo_found;
    logic [CH_W-1:0] hi_ch;
    logic [CH_W-1:0] lo_ch;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hi_found && pending[i] && (CH_W'(i) > last_grant)) begin
        hi_found = 1'b1;
        hi_ch    = CH_W'(i);
      end
      if (!lo_found && pending[i] && (CH_W'(i) <= last_grant)) begin
        lo_found = 1'b1;
        lo_ch    = CH_W'(i);
      end
    end
    grant_any = hi_found | lo_found;
    grant_ch  = hi_found ? hi_ch : lo_ch;
  end

  // Next-state logic and the per-state action strobes used by the
  // datapath processes below.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    do_wb      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          do_grant  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng.eng_done) begin
          do_capture = 1'b1;
          state_nxt  = WB;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WB: begin
        do_wb     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign eng.eng_start = (state == ISSUE);
  assign busy          = (state != IDLE);

  // One-hot of the channel being granted this cycle, used to clear its
  // pending bit.
  always_comb begin
    grant_clear = '0;
    if (do_grant) begin
      grant_clear[grant_ch] = 1'b1;
    end
  end

  // Pending requests and sticky error flags. A request on the channel
  // being granted re-arms pending for a follow-up job rather than flagging
  // an overrun. A new set event wins over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      overrun     <= '0;
      timeout_err <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pending[i] <= req[i] | (pending[i] & ~grant_clear[i]);
        if (req[i] && pending[i] && !grant_clear[i]) begin
          overrun[i] <= 1'b1;
        end else if (clr_err) begin
          overrun[i] <= 1'b0;
        end
      end
      if (do_timeout) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Cycles spent waiting for the engine; restarted on every issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !eng.eng_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Engine-side snapshot, result capture and writeback. The eng_* bus is
  // only loaded at grant so it stays stable for the whole job. A timed-out
  // job still advances last_grant so a dead channel cannot monopolise the
  // engine, but its state and output are left alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng.eng_ch         <= '0;
      eng.eng_setpoint   <= '0;
      eng.eng_feedback   <= '0;
      eng.eng_prev_error <= '0;
      eng.eng_integral   <= '0;
      cap_control        <= '0;
      cap_error          <= '0;
      cap_integral       <= '0;
      last_grant         <= CH_W'(NCH - 1);
      control_out        <= '0;
      ch_valid           <= '0;
      for (int i = 0; i < NCH; i++) begin
        prev_error[i] <= '0;
        integral[i]   <= '0;
      end
    end else begin
      ch_valid <= '0;

      if (do_grant) begin
        eng.eng_ch <= grant_ch;
        for (int i = 0; i < NCH; i++) begin
          if (grant_ch == CH_W'(i)) begin
            eng.eng_setpoint   <= setpoint[8*i +: 8];
            eng.eng_feedback   <= feedback[8*i +: 8];
            eng.eng_prev_error <= prev_error[i];
            eng.eng_integral   <= integral[i];
          end
        end
      end

      if (do_capture) begin
        cap_control  <= eng.eng_control;
        cap_error    <= eng.eng_error;
        cap_integral <= eng.eng_integral_nxt;
      end

      if (do_timeout) begin
        last_grant <= eng.eng_ch;
      end

      if (do_wb) begin
        last_grant <= eng.eng_ch;
        for (int i = 0; i < NCH; i++) begin
          if (eng.eng_ch == CH_W'(i)) begin
            control_out[8*i +: 8] <= cap_control;
            prev_error[i]         <= cap_error;
            integral[i]           <= cap_integral;
            ch_valid[i]           <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pid_channel_scheduler
//
// Directed bench for pid_channel_scheduler with NCH=4, TIMEOUT=64. The
// engine side of the interface is driven by hand; expected control outputs
// are tracked in a small per-channel table.
// ---------------------------------------------------------------------------
module tb_pid_channel_scheduler;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req;
  logic [8*NCH-1:0] setpoint;
  logic [8*NCH-1:0] feedback;
  logic             clr_err;
  logic [8*NCH-1:0] control_out;
  logic [NCH-1:0]   ch_valid;
  logic             busy;
  logic [NCH-1:0]   overrun;
  logic             timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_ctrl [NCH];

  pid_channel_scheduler_if #(.NCH(NCH)) eng_bus ();

  pid_channel_scheduler #(
    .NCH     (NCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .setpoint    (setpoint),
    .feedback    (feedback),
    .clr_err     (clr_err),
    .eng         (eng_bus),
    .control_out (control_out),
    .ch_valid    (ch_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Safety net in case the design wedges somewhere unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single checking point for every comparison.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Packs the expected control table the same way control_out is laid out.
  function automatic logic [31:0] expPacked();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      v[8*i +: 8] = exp_ctrl[i];
    end
    return v;
  endfunction

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold req for exactly one cycle.
  task automatic applyStimulus(input logic [NCH-1:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  // Wait (bounded) for eng_start, then check the granted channel.
  task automatic waitStart(input int exp_ch, input string tag);
    int n;
    n = 0;
    while (!eng_bus.eng_start && n < 200) begin
      tick();
      n++;
    end
    if (!eng_bus.eng_start) begin
      checkOutput({tag, "_start_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput(tag, 32'(eng_bus.eng_ch), 32'(exp_ch));
    end
  endtask

  // After `delay` cycles, pulse eng_done with a result; then check the
  // writeback two cycles after done.
  task automatic finishJob(input int ch, input logic [7:0] ctrl,
                           input logic [15:0] err, input logic [15:0] integ,
                           input int delay, input string tag);
    repeat (delay) tick();
    eng_bus.eng_done         = 1'b1;
    eng_bus.eng_control      = ctrl;
    eng_bus.eng_error        = err;
    eng_bus.eng_integral_nxt = integ;
    tick();
    eng_bus.eng_done = 1'b0;
    checkOutput({tag, "_valid_early"}, 32'(ch_valid), 32'd0);
    tick();
    exp_ctrl[ch] = ctrl;
    checkOutput({tag, "_ctrl"}, control_out, expPacked());
    checkOutput({tag, "_valid"}, 32'(ch_valid), 32'd1 << ch);
  endtask

  initial begin
    int starts;
    logic [31:0] saved_ctrl;

    rst_n    = 1'b0;
    req      = '0;
    clr_err  = 1'b0;
    setpoint = 32'h44332211;
    feedback = 32'h88776655;
    eng_bus.eng_done         = 1'b0;
    eng_bus.eng_control      = '0;
    eng_bus.eng_error        = '0;
    eng_bus.eng_integral_nxt = '0;
    for (int i = 0; i < NCH; i++) exp_ctrl[i] = 8'h00;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_control_out", control_out, 32'd0);
    checkOutput("rst_ch_valid", 32'(ch_valid), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_eng_start", 32'(eng_bus.eng_start), 32'd0);
    checkOutput("rst_eng_ch", 32'(eng_bus.eng_ch), 32'd0);
    checkOutput("rst_eng_setpoint", 32'(eng_bus.eng_setpoint), 32'd0);
    checkOutput("rst_eng_prev_error", 32'(eng_bus.eng_prev_error), 32'd0);
    checkOutput("rst_eng_integral", 32'(eng_bus.eng_integral), 32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin: all four at once are served 0,1,2,3.
    applyStimulus(4'b1111);
    for (int k = 0; k < NCH; k++) begin
      waitStart(k, $sformatf("rr_grant%0d", k));
      checkOutput($sformatf("rr_setpoint%0d", k), 32'(eng_bus.eng_setpoint),
                  32'(8'h11 * (k + 1)));
      finishJob(k, 8'(8'h10 + k), 16'(16'h0100 + k), 16'(16'h1000 + k), 1,
                $sformatf("rr_job%0d", k));
    end
    // After 3 was served, 0 outranks 3.
    applyStimulus(4'b1001);
    waitStart(0, "rr_wrap_first");
    finishJob(0, 8'h20, 16'h0200, 16'h2000, 1, "rr_wrap0");
    waitStart(3, "rr_wrap_second");
    finishJob(3, 8'h23, 16'h0203, 16'h2003, 1, "rr_wrap3");

    // Single request on channel 2, engine answers 3 cycles after start.
    applyStimulus(4'b0100);
    checkOutput("single_no_start_t1", 32'(eng_bus.eng_start), 32'd0);
    tick();
    checkOutput("single_start_t2", 32'(eng_bus.eng_start), 32'd1);
    checkOutput("single_eng_ch", 32'(eng_bus.eng_ch), 32'd2);
    checkOutput("single_setpoint", 32'(eng_bus.eng_setpoint), 32'h33);
    checkOutput("single_feedback", 32'(eng_bus.eng_feedback), 32'h77);
    checkOutput("single_prev_error", 32'(eng_bus.eng_prev_error), 32'h0102);
    finishJob(2, 8'h5A, 16'h0010, 16'h0100, 3, "single");
    checkOutput("single_idle_after", 32'(busy), 32'd0);
    tick();
    checkOutput("single_valid_pulse_end", 32'(ch_valid), 32'd0);
    applyStimulus(4'b0100);
    waitStart(2, "single2_ch");
    checkOutput("single2_prev_error", 32'(eng_bus.eng_prev_error), 32'h0010);
    checkOutput("single2_integral", 32'(eng_bus.eng_integral), 32'h0100);
    finishJob(2, 8'hA5, 16'h0020, 16'h0200, 1, "single2");

    // Overrun: two channel 1 requests behind a long channel 0 job.
    applyStimulus(4'b0001);
    waitStart(0, "ovr_ch0");
    applyStimulus(4'b0010);
    applyStimulus(4'b0010);
    checkOutput("ovr_flag", 32'(overrun), 32'b0010);
    finishJob(0, 8'h33, 16'h0003, 16'h0030, 5, "ovr_job0");
    waitStart(1, "ovr_ch1");
    finishJob(1, 8'h34, 16'h0004, 16'h0040, 1, "ovr_job1");
    starts = 0;
    repeat (10) begin
      if (eng_bus.eng_start) starts++;
      tick();
    end
    checkOutput("ovr_single_job", 32'(starts), 32'd0);
    checkOutput("ovr_flag_sticky", 32'(overrun), 32'b0010);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("ovr_cleared", 32'(overrun), 32'd0);

    // Re-request of channel 1 during its own WAIT.
    applyStimulus(4'b0010);
    waitStart(1, "rereq_ch1");
    tick();
    applyStimulus(4'b0010);
    checkOutput("rereq_no_overrun", 32'(overrun), 32'd0);
    finishJob(1, 8'h44, 16'h0044, 16'h0440, 1, "rereq_job1");
    waitStart(1, "rereq_second");
    finishJob(1, 8'h45, 16'h0045, 16'h0450, 1, "rereq_job2");

    // Timeout on channel 2, channel 3 waiting behind it.
    saved_ctrl = expPacked();
    applyStimulus(4'b1100);
    waitStart(2, "to_ch2");
    repeat (TIMEOUT) tick();
    checkOutput("to_not_yet", 32'(timeout_err), 32'd0);
    checkOutput("to_still_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("to_flag", 32'(timeout_err), 32'd1);
    checkOutput("to_idle", 32'(busy), 32'd0);
    checkOutput("to_ctrl_unchanged", control_out, saved_ctrl);
    checkOutput("to_no_valid", 32'(ch_valid), 32'd0);
    // Late done while in IDLE and ISSUE must be ignored.
    eng_bus.eng_done    = 1'b1;
    eng_bus.eng_control = 8'hEE;
    tick();
    checkOutput("to_next_start", 32'(eng_bus.eng_start), 32'd1);
    checkOutput("to_next_ch", 32'(eng_bus.eng_ch), 32'd3);
    tick();
    eng_bus.eng_done = 1'b0;
    tick();
    checkOutput("to_late_done_busy", 32'(busy), 32'd1);
    checkOutput("to_late_done_valid", 32'(ch_valid), 32'd0);
    checkOutput("to_late_done_ctrl", control_out, saved_ctrl);
    finishJob(3, 8'h66, 16'h0066, 16'h0660, 0, "to_job3");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("to_cleared", 32'(timeout_err), 32'd0);

    // Reset in the middle of a channel 1 WAIT, after a channel 0 job.
    applyStimulus(4'b0001);
    waitStart(0, "rst_pre_ch0");
    finishJob(0, 8'h77, 16'h0777, 16'h7000, 1, "rst_pre_job0");
    applyStimulus(4'b0010);
    waitStart(1, "rst_job_ch1");
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) exp_ctrl[i] = 8'h00;
    checkOutput("midrst_control_out", control_out, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_eng_start", 32'(eng_bus.eng_start), 32'd0);
    checkOutput("midrst_eng_ch", 32'(eng_bus.eng_ch), 32'd0);
    checkOutput("midrst_eng_setpoint", 32'(eng_bus.eng_setpoint), 32'd0);
    checkOutput("midrst_eng_prev_error", 32'(eng_bus.eng_prev_error), 32'd0);
    eng_bus.eng_done    = 1'b1;
    eng_bus.eng_control = 8'hCC;
    tick();
    eng_bus.eng_done = 1'b0;
    tick();
    checkOutput("midrst_late_ctrl", control_out, 32'd0);
    checkOutput("midrst_late_valid", 32'(ch_valid), 32'd0);
    checkOutput("midrst_late_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0011);
    waitStart(0, "midrst_first_grant");
    checkOutput("midrst_prev_error_cleared", 32'(eng_bus.eng_prev_error), 32'd0);
    checkOutput("midrst_integral_cleared", 32'(eng_bus.eng_integral), 32'd0);
    finishJob(0, 8'h81, 16'h0081, 16'h0810, 1, "midrst_job0");
    waitStart(1, "midrst_second_grant");
    finishJob(1, 8'h82, 16'h0082, 16'h0820, 1, "midrst_job1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pid_channel_scheduler.md
# pid_channel_scheduler

Time-shares one PID compute engine among NCH control loops. Latches per-channel sample requests, grants them round-robin, and drives the engine with a start/done handshake. Holds each channel's loop state (previous error, integral accumulator) and its registered control output. Sits between the chip I/O sampling logic and a single shared `pid_controller`-class datapath, so one multiplier/accumulator serves all loops.

## Interface
Parameters:
- NCH, 4: number of channels (2..8); CH_W = clog2(NCH)
- TIMEOUT, 64: maximum cycles in WAIT before the job is aborted

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NCH  sample request per channel; each high cycle is one request
- setpoint  in  8*NCH  per-channel setpoint; channel i at [8i+7:8i]
- feedback  in  8*NCH  per-channel measured value, same packing
- clr_err  in  1  clears the overrun and timeout sticky flags
- eng_start  out  1  one-cycle engine start pulse
- eng_ch  out  CH_W  channel being served
- eng_setpoint, eng_feedback  out  8 each  snapshot of the granted channel
- eng_prev_error, eng_integral  out  16 each  stored state of the granted channel
- eng_done  in  1  engine result valid (single-cycle pulse)
- eng_control  in  8  engine control result
- eng_error  in  16  engine error for this sample
- eng_integral_nxt  in  16  updated integral
- control_out  out  8*NCH  registered per-channel control value
- ch_valid  out  NCH  one-cycle pulse when control_out[i] updates
- busy  out  1  high in any state except IDLE
- overrun  out  NCH  sticky: request arrived while that channel was already pending
- timeout_err  out  1  sticky: engine failed to answer within TIMEOUT

## Operation
- Reset (rst_n low at an edge): all outputs 0, including control_out, ch_valid, flags, and eng_* outputs. Reset also clears pending, per-channel prev_error and integral, and the wait counter. The state goes to IDLE and last_grant = NCH-1, so channel 0 has first priority.
- pending[i] is set when req[i] is high. pending[i] is cleared when channel i is granted.
- If req[i] is high while pending[i] is already set and not being cleared that cycle, overrun[i] is set and the requests merge into one job.
- If req[i] is high in the same cycle channel i is granted, pending[i] stays set with no overrun; a new job follows.
- clr_err clears overrun and timeout_err. A new set event in the same cycle wins, so the flag stays 1.

FSM states:
- IDLE: if pending ≠ 0, grant the first set bit searching from last_grant+1 with wrap-around. Latch eng_ch, eng_setpoint, eng_feedback, eng_prev_error, eng_integral. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: eng_start = 1 for exactly this cycle; clear the wait counter; go to WAIT. eng_done is ignored in ISSUE.
- WAIT: on eng_done, capture the eng_control, eng_error and eng_integral_nxt results and go to WB. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done, set timeout_err and go to IDLE with no writeback; that channel's state and output are unchanged and last_grant is still updated.
- WB: write control_out[ch] = captured control, prev_error[ch] = captured error, integral[ch] = captured integral. Pulse ch_valid[ch] (registered, visible next cycle). Set last_grant = ch. Go to IDLE.
- eng_done outside WAIT is ignored.
- eng_* outputs hold stable from grant until the next grant.
- No arithmetic is performed here; the 16-bit state is stored and returned unmodified (signed, opaque).

## Timing
- req[i] high in cycle t → pending visible in t+1. If IDLE in t+1, eng_start is high in t+2.
- eng_done in cycle d (d ≥ t+3) → WB in d+1 → control_out and ch_valid visible in d+2, FSM back in IDLE in d+2. The next eng_start is at d+3 at the earliest.
- Minimum job is 4 cycles (IDLE, ISSUE, WAIT, WB) with a 1-cycle engine.
- A timed-out job occupies 1 + 1 + TIMEOUT cycles before IDLE.
- Starvation bound: a pending channel is served within NCH jobs.
- Reset mid-job aborts with no writeback. An eng_done arriving after reset is ignored.

## Test plan
- Single request: channel 2 req for 1 cycle, engine answers 3 cycles after start with control = 0x5A, error = 0x0010, integral = 0x0100. Required: eng_start in cycle t+2, eng_ch = 2, control_out[2] = 0x5A, and ch_valid[2] a single pulse at done+2. On the next channel 2 job, eng_prev_error = 0x0010 and eng_integral = 0x0100.
- Round-robin: req on all 4 channels in the same cycle → grants in order 0,1,2,3. Then a re-request of 0 and 3 together after serving 3 → 0 is granted before 3.
- Overrun: req[1] twice while it is pending behind a long channel 0 job → overrun = 4'b0010 and only one channel 1 job runs. clr_err → overrun = 0.
- Re-request during service: req[1] during its own WAIT → no overrun, and a second channel 1 job starts after WB.
- Timeout: engine never asserts done → timeout_err = 1 after TIMEOUT cycles in WAIT, control_out unchanged, FSM returns to IDLE and serves the next pending channel. A late eng_done is ignored.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 and state 0. A subsequent eng_done has no effect, and the first grant afterwards goes to channel 0.
